// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, width-parametrised ALU with a multi-cycle restoring
// divider. One operation is in flight at a time. Results are registered and
// held stable until the consumer takes them, then kept as last-delivered values.
module alu_pipe #(
  parameter int          WIDTH     = 8,
  parameter int unsigned BAD_VALUE = 32'hAC
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero,
  output logic             DivByZero,
  output logic             Illegal
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic             accept_s, start_div_s, div_done_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] quo_r, rem_r, dvs_r;
  logic [WIDTH-1:0] quo_nxt_s, rem_nxt_s;
  logic [WIDTH:0]   shift_s, trial_s;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_lo_s, res_hi_s;
  logic               carry_s, ovf_s, dbz_s, ill_s;

  logic [WIDTH-1:0] alu_out_r, alu_hi_r;
  logic             carry_r, ovf_r, zero_r, dbz_r, ill_r;

  // Handshake outputs come straight from the state register; in_ready is
  // additionally masked while reset is held so nothing is offered mid-reset.
  assign in_ready  = reset_n & (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_RESP);

  assign ALU_Out   = alu_out_r;
  assign ALU_Hi    = alu_hi_r;
  assign CarryOut  = carry_r;
  assign Overflow  = ovf_r;
  assign Zero      = zero_r;
  assign DivByZero = dbz_r;
  assign Illegal   = ill_r;

  assign sum_s  = {1'b0, A} + {1'b0, B};
  assign diff_s = A - B;
  assign prod_s = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic and datapath control strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    start_div_s = 1'b0;
    div_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if ((ALU_Sel == OP_DIV) && (B != {WIDTH{1'b0}})) begin
            start_div_s = 1'b1;
            state_nxt_s = ST_DIV;
          end else begin
            state_nxt_s = ST_RESP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (cnt_r == {CW{1'b0}}) begin
          div_done_s  = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract the
  // divisor if it fits (MSB of the W+1-bit trial clear), record the quotient bit.
  always_comb begin
    shift_s = {rem_r, quo_r[WIDTH-1]};
    trial_s = shift_s - {1'b0, dvs_r};
    if (!trial_s[WIDTH]) begin
      rem_nxt_s = trial_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt_s = shift_s[WIDTH-1:0];
      quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // Single-cycle results for every opcode except a real division; the DIV
  // entry here only covers the divide-by-zero bypass.
  always_comb begin
    res_lo_s = {WIDTH{1'b0}};
    res_hi_s = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    dbz_s    = 1'b0;
    ill_s    = 1'b0;
    case (ALU_Sel)
      OP_ADD: begin
        res_lo_s = sum_s[WIDTH-1:0];
        carry_s  = sum_s[WIDTH];
        ovf_s    = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo_s = diff_s;
        carry_s  = (A < B);
        ovf_s    = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_MUL: begin
        res_lo_s = prod_s[WIDTH-1:0];
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        carry_s  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
      end
      OP_DIV: begin
        res_lo_s = {WIDTH{1'b1}};
        res_hi_s = A;
        dbz_s    = 1'b1;
      end
      OP_AND:  res_lo_s = A & B;
      OP_OR:   res_lo_s = A | B;
      OP_XOR:  res_lo_s = A ^ B;
      OP_NOT:  res_lo_s = ~A;
      default: begin
        res_lo_s = WIDTH'(BAD_VALUE);
        ill_s    = 1'b1;
      end
    endcase
  end

  // Divider registers and result registers; results only change when a new
  // result is produced, so they hold through RESP and after delivery.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {CW{1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      alu_out_r <= {WIDTH{1'b0}};
      alu_hi_r  <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= 1'b0;
      dbz_r     <= 1'b0;
      ill_r     <= 1'b0;
    end else if (accept_s && start_div_s) begin
      quo_r <= A;
      rem_r <= {WIDTH{1'b0}};
      dvs_r <= B;
      cnt_r <= CW'(WIDTH - 1);
    end else if (accept_s) begin
      alu_out_r <= res_lo_s;
      alu_hi_r  <= res_hi_s;
      carry_r   <= carry_s;
      ovf_r     <= ovf_s;
      zero_r    <= (res_lo_s == {WIDTH{1'b0}});
      dbz_r     <= dbz_s;
      ill_r     <= ill_s;
    end else if (div_done_s) begin
      alu_out_r <= quo_nxt_s;
      alu_hi_r  <= rem_nxt_s;
      carry_r   <= 1'b0;
      ovf_r     <= 1'b0;
      zero_r    <= (quo_nxt_s == {WIDTH{1'b0}});
      dbz_r     <= 1'b0;
      ill_r     <= 1'b0;
    end else if (state_r == ST_DIV) begin
      quo_r <= quo_nxt_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r - CW'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8, BAD_VALUE=8'hAC).
module tb_alu_pipe;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] ALU_Sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ALU_Out;
  logic [7:0] ALU_Hi;
  logic       CarryOut;
  logic       Overflow;
  logic       Zero;
  logic       DivByZero;
  logic       Illegal;

  int passed = 0;
  int total  = 0;
  int cyc;
  logic flag;

  alu_pipe #(.WIDTH(8), .BAD_VALUE(32'hAC)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .ALU_Hi    (ALU_Hi),
    .CarryOut  (CarryOut),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .DivByZero (DivByZero),
    .Illegal   (Illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Result bundle: {out, hi, carry, overflow, zero, divbyzero, illegal}
  function automatic logic [20:0] pk(input logic [7:0] o, input logic [7:0] h,
                                     input logic c, input logic ov, input logic z,
                                     input logic d, input logic il);
    return {o, h, c, ov, z, d, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [7:0] o, input logic [7:0] h,
                           input logic c, input logic ov, input logic z,
                           input logic d, input logic il);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(pk(ALU_Out, ALU_Hi, CarryOut, Overflow, Zero, DivByZero, Illegal)),
          32'(pk(o, h, c, ov, z, d, il)));
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge
  // with inputs scrambled so any late sampling would show.
  task automatic send(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    ALU_Sel  = sel;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    A        = 8'h5A;
    B        = 8'hA5;
    ALU_Sel  = 4'h9;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, "_no_ready_in_resp"}, 32'(in_ready), 32'd0);
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 8'h00;
    B         = 8'h00;
    ALU_Sel   = 4'h0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'(pk(ALU_Out, ALU_Hi, CarryOut, Overflow, Zero, DivByZero, Illegal)), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // add with carry
    send(4'd0, 8'hF0, 8'h20);
    check_res("add_f0_20", 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("add1");
    // add signed overflow
    send(4'd0, 8'h7F, 8'h01);
    check_res("add_7f_01", 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake("add2");
    // subtract
    send(4'd1, 8'h80, 8'h01);
    check_res("sub_80_01", 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    handshake("sub1");
    send(4'd1, 8'h01, 8'h02);
    check_res("sub_01_02", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("sub2");
    // multiply
    send(4'd2, 8'h10, 8'h10);
    check_res("mul_10_10", 8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    handshake("mul1");
    send(4'd2, 8'hFF, 8'hFF);
    check_res("mul_ff_ff", 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("mul2");
    // logic ops
    send(4'd4, 8'hF0, 8'h3C);
    check_res("and", 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("and");
    send(4'd5, 8'hF0, 8'h0F);
    check_res("or", 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("or");
    send(4'd6, 8'h5A, 8'h5A);
    check_res("xor_zero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    handshake("xor");
    send(4'd7, 8'h0F, 8'hFF);
    check_res("not", 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("not");

    // divide 200 / 7 = 28 r 4, nine cycles to out_valid
    send(4'd3, 8'd200, 8'd7);
    cyc  = 1;
    flag = 1'b1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      if (in_ready !== 1'b0) flag = 1'b0;
      @(negedge clock);
      cyc++;
    end
    check("div_latency", 32'(cyc), 32'd9);
    check("div_in_ready_low", 32'(flag), 32'd1);
    check("div_in_ready_resp", 32'(in_ready), 32'd0);
    check_res("div_200_7", 8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("div1");

    // divide by zero bypass
    send(4'd3, 8'h55, 8'h00);
    check_res("div_by_zero", 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    handshake("div0");

    // illegal opcode held under back-pressure, in_valid pulses ignored
    send(4'hF, 8'h12, 8'h34);
    for (int i = 0; i < 5; i++) begin
      check_res("illegal_hold", 8'hAC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("illegal_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      ALU_Sel  = 4'd0;
      A        = 8'h01;
      B        = 8'h01;
      @(negedge clock);
    end
    in_valid = 1'b0;
    check_res("illegal_final", 8'hAC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    handshake("illegal");
    @(negedge clock);
    check("no_queued_op", 32'(out_valid), 32'd0);
    check("held_after_delivery", 32'(ALU_Out), 32'hAC);

    // reset during division
    send(4'd3, 8'hFF, 8'h03);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_outputs", 32'(pk(ALU_Out, ALU_Hi, CarryOut, Overflow, Zero, DivByZero, Illegal)), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    flag = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || ALU_Out !== 8'h00) flag = 1'b1;
    end
    check("postrst_no_stale", 32'(flag), 32'd0);
    send(4'd0, 8'h01, 8'h01);
    check_res("postrst_add", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    handshake("postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
